// File: rtl/alu_cmd_sequencer.sv
// Command/result wrapper around the registered 8-bit ALU. Commands are queued and
// issued with result-slot credits, and results are captured in issue order.
module alu_cmd_sequencer #(
    parameter int BITS      = 8,
    parameter int TAG_W     = 4,
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [BITS-1:0]  i_cmd_a,
    input  logic [BITS-1:0]  i_cmd_b,
    input  logic [1:0]       i_cmd_op,
    input  logic [TAG_W-1:0] i_cmd_tag,
    output logic [BITS-1:0]  o_alu_a,
    output logic [BITS-1:0]  o_alu_b,
    output logic [1:0]       o_alu_op,
    input  logic [BITS-1:0]  i_alu_out,
    input  logic [3:0]       i_alu_status,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [BITS-1:0]  o_res_data,
    output logic [3:0]       o_res_status,
    output logic [TAG_W-1:0] o_res_tag,
    output logic             o_busy,
    output logic [15:0]      o_issue_cnt
);

    localparam int CA = $clog2(CMD_DEPTH);
    localparam int RA = $clog2(RES_DEPTH);
    localparam int CW = 2*BITS + 2 + TAG_W;
    localparam int RW = BITS + 4 + TAG_W;

    logic [CW-1:0]    cmd_mem [CMD_DEPTH];
    logic [CA:0]      cmd_wr, cmd_rd;
    logic [CA:0]      cmd_count;
    logic             cmd_full, cmd_empty, cmd_push;
    logic [CW-1:0]    cmd_head;

    logic [RW-1:0]    res_mem [RES_DEPTH];
    logic [RA:0]      res_wr, res_rd;
    logic [RA:0]      res_count;
    logic             res_empty, res_pop;

    logic             v1, v2;
    logic [TAG_W-1:0] tag1, tag2;
    logic [RA+1:0]    credit_used;
    logic             issue;

    logic [BITS-1:0]  head_a, head_b;
    logic [1:0]       head_op;
    logic [TAG_W-1:0] head_tag;

    assign cmd_count   = cmd_wr - cmd_rd;
    assign cmd_full    = (cmd_count == (CA+1)'(CMD_DEPTH));
    assign cmd_empty   = (cmd_wr == cmd_rd);
    assign o_cmd_ready = !cmd_full;
    assign cmd_push    = i_cmd_valid && !cmd_full;
    assign cmd_head    = cmd_mem[cmd_rd[CA-1:0]];
    assign {head_a, head_b, head_op, head_tag} = cmd_head;

    assign res_count   = res_wr - res_rd;
    assign res_empty   = (res_wr == res_rd);
    assign o_res_valid = !res_empty;
    assign res_pop     = o_res_valid && i_res_ready;

    // Every issued-but-uncaptured command reserves a result slot, so capture never stalls.
    assign credit_used = {1'b0, res_count} + (RA+2)'(v1) + (RA+2)'(v2);
    assign issue       = !cmd_empty && (credit_used < (RA+2)'(RES_DEPTH));

    // Head is gated so the outputs read zero whenever nothing is pending, including after reset.
    always_comb begin
        {o_res_tag, o_res_status, o_res_data} = '0;
        if (!res_empty)
            {o_res_tag, o_res_status, o_res_data} = res_mem[res_rd[RA-1:0]];
    end

    assign o_busy = !cmd_empty || v1 || v2 || !res_empty;

    always_ff @(posedge i_clk) begin
        if (cmd_push)
            cmd_mem[cmd_wr[CA-1:0]] <= {i_cmd_a, i_cmd_b, i_cmd_op, i_cmd_tag};
        if (v2)
            res_mem[res_wr[RA-1:0]] <= {tag2, i_alu_status, i_alu_out};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            cmd_wr      <= '0;
            cmd_rd      <= '0;
            res_wr      <= '0;
            res_rd      <= '0;
            v1          <= 1'b0;
            v2          <= 1'b0;
            tag1        <= '0;
            tag2        <= '0;
            o_alu_a     <= '0;
            o_alu_b     <= '0;
            o_alu_op    <= '0;
            o_issue_cnt <= '0;
        end else begin
            if (cmd_push)
                cmd_wr <= cmd_wr + (CA+1)'(1);
            if (issue) begin
                cmd_rd      <= cmd_rd + (CA+1)'(1);
                o_alu_a     <= head_a;
                o_alu_b     <= head_b;
                o_alu_op    <= head_op;
                tag1        <= head_tag;
                o_issue_cnt <= o_issue_cnt + 16'd1;
            end
            v1   <= issue;
            v2   <= v1;
            tag2 <= tag1;
            if (v2)
                res_wr <= res_wr + (RA+1)'(1);
            if (res_pop)
                res_rd <= res_rd + (RA+1)'(1);
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural registered ALU attached.
module tb_alu_cmd_sequencer;

    logic       i_clk;
    logic       i_rst;
    logic       i_cmd_valid;
    logic       o_cmd_ready;
    logic [7:0] i_cmd_a, i_cmd_b;
    logic [1:0] i_cmd_op;
    logic [3:0] i_cmd_tag;
    logic [7:0] o_alu_a, o_alu_b;
    logic [1:0] o_alu_op;
    logic [7:0] i_alu_out;
    logic [3:0] i_alu_status;
    logic       o_res_valid;
    logic       i_res_ready;
    logic [7:0] o_res_data;
    logic [3:0] o_res_status;
    logic [3:0] o_res_tag;
    logic       o_busy;
    logic [15:0] o_issue_cnt;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic rec_en = 1'b1;

    logic [7:0] res_d[$];
    logic [3:0] res_s[$];
    logic [3:0] res_t[$];
    int         res_c[$];

    alu_cmd_sequencer #(.BITS(8), .TAG_W(4), .CMD_DEPTH(4), .RES_DEPTH(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_a(i_cmd_a), .i_cmd_b(i_cmd_b), .i_cmd_op(i_cmd_op), .i_cmd_tag(i_cmd_tag),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
        .i_alu_out(i_alu_out), .i_alu_status(i_alu_status),
        .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
        .o_res_data(o_res_data), .o_res_status(o_res_status), .o_res_tag(o_res_tag),
        .o_busy(o_busy), .o_issue_cnt(o_issue_cnt)
    );

    // Reference ALU: one-cycle input register, status = {N, Z, C(borrow), V}.
    logic [7:0] ra, rb;
    logic [1:0] rop;
    always @(posedge i_clk) begin
        if (!i_rst) begin
            ra <= '0; rb <= '0; rop <= '0;
        end else begin
            ra <= o_alu_a; rb <= o_alu_b; rop <= o_alu_op;
        end
    end

    function automatic logic [11:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        logic [7:0] r;
        logic [7:0] o;
        logic n, z, c, v;
        r = a - b;
        o = r;
        c = 1'b0;
        v = 1'b0;
        case (op)
            2'b00: begin c = (a < b); v = (a[7] != b[7]) && (r[7] != a[7]); end
            2'b01: begin c = (a < b); v = (a[7] != b[7]) && (r[7] != a[7]);
                         o = {6'b0, a == b, a < b}; end
            2'b10: begin r = a << b[2:0]; o = r; end
            default: begin r = a ^ (8'd1 << b[2:0]); o = r; end
        endcase
        n = r[7];
        z = (r == 8'd0);
        return {n, z, c, v, o};
    endfunction

    always_comb {i_alu_status, i_alu_out} = alu_f(ra, rb, rop);

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (rec_en && i_rst && o_res_valid && i_res_ready) begin
            res_d.push_back(o_res_data);
            res_s.push_back(o_res_status);
            res_t.push_back(o_res_tag);
            res_c.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_q();
        res_d.delete(); res_s.delete(); res_t.delete(); res_c.delete();
    endtask

    task automatic do_reset();
        i_rst = 1'b0;
        i_cmd_valid = 1'b0;
        i_res_ready = 1'b0;
        tick();
        tick();
        i_rst = 1'b1;
        clear_q();
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag);
        int n;
        n = 0;
        i_cmd_valid = 1'b1;
        i_cmd_op = op; i_cmd_a = a; i_cmd_b = b; i_cmd_tag = tag;
        while (!o_cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            tests++; fails++;
            $display("FAIL send_timeout tag=%0d: o_cmd_ready stayed %b, required 1", tag, o_cmd_ready);
        end else begin
            tick();
        end
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int k;
        k = 0;
        while (res_d.size() < n && k < 200) begin
            tick();
            k++;
        end
        if (res_d.size() < n) begin
            tests++; fails++;
            $display("FAIL result_timeout: got %0d results, required %0d", res_d.size(), n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (o_cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready: got %b, required 1", o_cmd_ready); end
        tests++; if (o_res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid: got %b, required 0", o_res_valid); end
        tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", o_busy); end
        tests++; if (o_issue_cnt !== 16'd0) begin fails++; $display("FAIL reset_issue_cnt: got %0d, required 0", o_issue_cnt); end
        tests++; if ({o_res_data, o_res_status, o_res_tag} !== 16'h0) begin fails++;
            $display("FAIL reset_res_head: got %h/%h/%h, required 0/0/0", o_res_data, o_res_status, o_res_tag); end
        tests++; if ({o_alu_a, o_alu_b, o_alu_op} !== 18'h0) begin fails++;
            $display("FAIL reset_alu_regs: got %h/%h/%h, required 0/0/0", o_alu_a, o_alu_b, o_alu_op); end
    endtask

    task automatic test_single();
        logic [3:0] vseq;
        do_reset();
        send_cmd(2'b00, 8'd5, 8'd3, 4'd1);
        vseq[0] = o_res_valid;
        tick();
        tests++; if ({o_alu_a, o_alu_b, o_alu_op} !== {8'd5, 8'd3, 2'b00}) begin fails++;
            $display("FAIL single_alu_load: got %0d/%0d/%0d, required 5/3/0", o_alu_a, o_alu_b, o_alu_op); end
        vseq[1] = o_res_valid;
        tick(); vseq[2] = o_res_valid;
        tick(); vseq[3] = o_res_valid;
        tests++; if (vseq !== 4'b1000) begin fails++; $display("FAIL single_latency: valid sequence %b, required 1000", vseq); end
        tests++; if (o_res_data !== 8'd2) begin fails++; $display("FAIL single_data: got %0d, required 2", o_res_data); end
        tests++; if (o_res_tag !== 4'd1) begin fails++; $display("FAIL single_tag: got %0d, required 1", o_res_tag); end
        tests++; if (o_res_status !== 4'b0000) begin fails++; $display("FAIL single_status: got %b, required 0000", o_res_status); end
        i_res_ready = 1'b1;
        tick();
        i_res_ready = 1'b0;
        tests++; if ({o_res_valid, o_busy} !== 2'b00) begin fails++;
            $display("FAIL single_drain: valid/busy %b%b, required 00", o_res_valid, o_busy); end
        tests++; if (o_issue_cnt !== 16'd1) begin fails++; $display("FAIL single_issue_cnt: got %0d, required 1", o_issue_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        i_res_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_cmd(2'b00, 8'(10 + i), 8'(i), 4'(i));
        wait_results(8);
        for (int i = 0; i < 8 && i < res_d.size(); i++) begin
            tests++; if (res_d[i] !== 8'd10 || res_t[i] !== 4'(i) || res_s[i] !== 4'b0000) begin fails++;
                $display("FAIL burst_result[%0d]: got d=%0d t=%0d s=%b, required d=10 t=%0d s=0000", i, res_d[i], res_t[i], res_s[i], i); end
            if (i > 0) begin
                tests++; if (res_c[i] !== res_c[i-1] + 1) begin fails++;
                    $display("FAIL burst_spacing[%0d]: cycle gap %0d, required 1", i, res_c[i] - res_c[i-1]); end
            end
        end
        tests++; if (o_issue_cnt !== 16'd8) begin fails++; $display("FAIL burst_issue_cnt: got %0d, required 8", o_issue_cnt); end
        i_res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 8; i++) send_cmd(2'b00, 8'(10 + i), 8'(i), 4'(i));
        i_cmd_valid = 1'b1;
        i_cmd_op = 2'b00; i_cmd_a = 8'd18; i_cmd_b = 8'd8; i_cmd_tag = 4'd8;
        for (int i = 0; i < 5; i++) tick();
        tests++; if (o_issue_cnt !== 16'd4) begin fails++; $display("FAIL bp_issued: got %0d, required 4", o_issue_cnt); end
        tests++; if (o_cmd_ready !== 1'b0) begin fails++; $display("FAIL bp_cmd_ready: got %b, required 0", o_cmd_ready); end
        tests++; if (o_res_valid !== 1'b1 || o_res_tag !== 4'd0) begin fails++;
            $display("FAIL bp_head: valid=%b tag=%0d, required valid=1 tag=0", o_res_valid, o_res_tag); end
        i_res_ready = 1'b1;
        send_cmd(2'b00, 8'd18, 8'd8, 4'd8);
        send_cmd(2'b00, 8'd19, 8'd9, 4'd9);
        wait_results(10);
        for (int i = 0; i < 10 && i < res_d.size(); i++) begin
            tests++; if (res_t[i] !== 4'(i) || res_d[i] !== 8'd10) begin fails++;
                $display("FAIL bp_order[%0d]: got t=%0d d=%0d, required t=%0d d=10", i, res_t[i], res_d[i], i); end
        end
        tests++; if (o_issue_cnt !== 16'd10) begin fails++; $display("FAIL bp_issue_cnt: got %0d, required 10", o_issue_cnt); end
        i_res_ready = 1'b0;
    endtask

    task automatic test_mixed_ops();
        logic [7:0] ed [5];
        logic [3:0] es [5];
        ed[0] = 8'h01; es[0] = 4'b1010;
        ed[1] = 8'h0C; es[1] = 4'b0000;
        ed[2] = 8'h8F; es[2] = 4'b1000;
        ed[3] = 8'h7F; es[3] = 4'b0001;
        ed[4] = 8'h00; es[4] = 4'b0100;
        do_reset();
        i_res_ready = 1'b1;
        send_cmd(2'b01, 8'd3,   8'd7, 4'd2);
        send_cmd(2'b10, 8'd3,   8'd2, 4'd3);
        send_cmd(2'b11, 8'h0F,  8'd7, 4'd4);
        send_cmd(2'b00, 8'h80,  8'd1, 4'd5);
        send_cmd(2'b00, 8'd9,   8'd9, 4'd6);
        wait_results(5);
        for (int i = 0; i < 5 && i < res_d.size(); i++) begin
            tests++; if (res_d[i] !== ed[i] || res_s[i] !== es[i] || res_t[i] !== 4'(i + 2)) begin fails++;
                $display("FAIL mixed[%0d]: got d=%h s=%b t=%0d, required d=%h s=%b t=%0d",
                         i, res_d[i], res_s[i], res_t[i], ed[i], es[i], i + 2); end
        end
        i_res_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen;
        do_reset();
        for (int i = 0; i < 6; i++) send_cmd(2'b00, 8'(20 + i), 8'd1, 4'(i));
        i_rst = 1'b0;
        tick();
        i_rst = 1'b1;
        tests++; if ({o_res_valid, o_busy, o_cmd_ready} !== 3'b001) begin fails++;
            $display("FAIL midreset_flags: valid/busy/ready %b%b%b, required 001", o_res_valid, o_busy, o_cmd_ready); end
        tests++; if (o_issue_cnt !== 16'd0) begin fails++; $display("FAIL midreset_issue_cnt: got %0d, required 0", o_issue_cnt); end
        clear_q();
        i_res_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (o_res_valid) seen++;
            tick();
        end
        tests++; if (seen != 0 || res_d.size() != 0) begin fails++;
            $display("FAIL midreset_stale: %0d valid cycles, %0d results, required 0/0", seen, res_d.size()); end
        i_res_ready = 1'b0;
    endtask

    task automatic test_issue_wrap();
        int acc, budget;
        do_reset();
        rec_en = 1'b0;
        i_res_ready = 1'b1;
        i_cmd_valid = 1'b1;
        i_cmd_op = 2'b00; i_cmd_a = 8'd1; i_cmd_b = 8'd0; i_cmd_tag = 4'd0;
        acc = 0;
        budget = 0;
        while (acc < 65535 && budget < 70000) begin
            if (o_cmd_ready) acc++;
            tick();
            budget++;
        end
        i_cmd_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        tests++; if (acc != 65535) begin fails++; $display("FAIL wrap_accepts: got %0d, required 65535", acc); end
        tests++; if (o_issue_cnt !== 16'hFFFF) begin fails++; $display("FAIL wrap_preload: got %0d, required 65535", o_issue_cnt); end
        send_cmd(2'b00, 8'd1, 8'd0, 4'd1);
        tick();
        tests++; if (o_issue_cnt !== 16'd0) begin fails++; $display("FAIL wrap_rollover: got %0d, required 0", o_issue_cnt); end
        for (int i = 0; i < 4; i++) tick();
        tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL wrap_idle: busy=%b, required 0", o_busy); end
        rec_en = 1'b1;
        i_res_ready = 1'b0;
    endtask

    initial begin
        i_rst = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_a = '0; i_cmd_b = '0; i_cmd_op = '0; i_cmd_tag = '0;
        i_res_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_mixed_ops();
        test_reset_mid();
        test_issue_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
